// File: rtl/proc_pkg.sv
// -----------------------------------------------------------------------------
// proc_pkg
// Shared definitions for the 8-bit single-cycle processor. The ALU, the control
// unit and the register file all import this package.
//   DATA_W    : datapath / register width
//   ADDR_W    : register index width
//   NREGS     : number of general-purpose registers
//   data_t    : one datapath word
//   regaddr_t : one register index
// -----------------------------------------------------------------------------
package proc_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int NREGS  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] regaddr_t;

endpackage : proc_pkg

// File: rtl/reg_file_8x8_reg_cell.sv
// -----------------------------------------------------------------------------
// reg_cell
// One register of the register file: asynchronous active-low clear, loads d on
// the rising clock edge when en is high, otherwise holds.
// Ports:
//   clk   : clock
//   rst_n : asynchronous active-low clear
//   en    : load enable
//   d     : load data
//   q     : stored value
// -----------------------------------------------------------------------------
import proc_pkg::*;

module reg_cell #(
    parameter int W = DATA_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_r;

    // Storage element: cleared asynchronously, loaded when enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_r <= {W{1'b0}};
        end else if (en) begin
            q_r <= d;
        end else begin
            q_r <= q_r;
        end
    end

    assign q = q_r;

endmodule : reg_cell

// File: rtl/reg_file_8x8.sv
// -----------------------------------------------------------------------------
// reg_file_8x8
// General-purpose register file of the 8-bit single-cycle processor: 8 x 8-bit
// registers, one write port (captures the write-back value on the rising edge),
// two combinational read ports feeding the ALU operands.
// Writes are suppressed while BUSYWAIT is high so a stalled instruction never
// commits; it commits on the first edge with BUSYWAIT low.
// Ports:
//   CLK         : clock, writes on rising edge
//   RESET_N     : asynchronous active-low reset, clears every register
//   IN          : write data
//   INADDRESS   : destination register index
//   WRITE       : write enable from the control unit
//   BUSYWAIT    : memory stall, 1 = hold all registers
//   OUT1ADDRESS : read port 1 index
//   OUT2ADDRESS : read port 2 index
//   OUT1        : read port 1 data
//   OUT2        : read port 2 data
// Build option:
//   REGFILE_BYPASS_EN : when defined, a qualifying write is forwarded
//                       combinationally to any read port addressing the
//                       destination register in the same cycle.
// -----------------------------------------------------------------------------
import proc_pkg::*;

module reg_file_8x8 #(
    parameter int DATA_W = proc_pkg::DATA_W,
    parameter int ADDR_W = proc_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic [DATA_W-1:0] IN,
    input  logic [ADDR_W-1:0] INADDRESS,
    input  logic              WRITE,
    input  logic              BUSYWAIT,
    input  logic [ADDR_W-1:0] OUT1ADDRESS,
    input  logic [ADDR_W-1:0] OUT2ADDRESS,
    output logic [DATA_W-1:0] OUT1,
    output logic [DATA_W-1:0] OUT2
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic              we_s;
    logic [DATA_W-1:0] regs_s [NUM_REGS];
    logic [DATA_W-1:0] out1_s;
    logic [DATA_W-1:0] out2_s;

    // Reset is folded in so the bypass path is also inactive during reset.
    assign we_s = WRITE & ~BUSYWAIT & RESET_N;

    // One cell per register; the decoder selects exactly one cell per write.
    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        logic en_s;
        assign en_s = we_s & (INADDRESS == ADDR_W'(i));

        reg_cell #(
            .W (DATA_W)
        ) u_cell (
            .clk   (CLK),
            .rst_n (RESET_N),
            .en    (en_s),
            .d     (IN),
            .q     (regs_s[i])
        );
    end

    // Two independent 8:1 read muxes, optionally with write-through bypass.
    always_comb begin
        out1_s = regs_s[OUT1ADDRESS];
        out2_s = regs_s[OUT2ADDRESS];
`ifdef REGFILE_BYPASS_EN
        if (we_s && (OUT1ADDRESS == INADDRESS)) begin
            out1_s = IN;
        end else begin
            out1_s = regs_s[OUT1ADDRESS];
        end
        if (we_s && (OUT2ADDRESS == INADDRESS)) begin
            out2_s = IN;
        end else begin
            out2_s = regs_s[OUT2ADDRESS];
        end
`endif
    end

    assign OUT1 = out1_s;
    assign OUT2 = out2_s;

endmodule : reg_file_8x8

// File: tb/tb_reg_file_8x8.sv
// -----------------------------------------------------------------------------
// tb_reg_file_8x8
// Self-checking bench for reg_file_8x8. A plain array of eight bytes models the
// architectural register state; it is updated whenever the bench applies a
// clock edge with a qualifying write, and cleared whenever reset is asserted.
// -----------------------------------------------------------------------------
module tb_reg_file_8x8;

    logic       CLK;
    logic       RESET_N;
    logic [7:0] IN;
    logic [2:0] INADDRESS;
    logic       WRITE;
    logic       BUSYWAIT;
    logic [2:0] OUT1ADDRESS;
    logic [2:0] OUT2ADDRESS;
    logic [7:0] OUT1;
    logic [7:0] OUT2;

    logic [7:0] model [8];
    int n_tests = 0;
    int n_fail  = 0;

    reg_file_8x8 dut (
        .CLK         (CLK),
        .RESET_N     (RESET_N),
        .IN          (IN),
        .INADDRESS   (INADDRESS),
        .WRITE       (WRITE),
        .BUSYWAIT    (BUSYWAIT),
        .OUT1ADDRESS (OUT1ADDRESS),
        .OUT2ADDRESS (OUT2ADDRESS),
        .OUT1        (OUT1),
        .OUT2        (OUT2)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Expected read value for an address given the model and current inputs.
    function automatic logic [7:0] exp_rd(input logic [2:0] a);
        logic [7:0] v;
        v = model[a];
`ifdef REGFILE_BYPASS_EN
        if (WRITE && !BUSYWAIT && RESET_N && (a == INADDRESS)) v = IN;
`endif
        if (!RESET_N) v = 8'h00;
        return v;
    endfunction

    task automatic clear_model();
        for (int i = 0; i < 8; i++) model[i] = 8'h00;
    endtask

    // One rising edge: the model commits a qualifying write, then settle.
    task automatic tick();
        @(posedge CLK);
        if (RESET_N && WRITE && !BUSYWAIT) model[INADDRESS] = IN;
        #1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0; clear_model();
        #2;
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(7 - a);
            #1;
            n_tests++;
            if (OUT1 !== 8'h00 || OUT2 !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_init a=%0d: got %h/%h want 00/00", a, OUT1, OUT2);
            end
        end
        @(negedge CLK);
        RESET_N = 1'b1; WRITE = 1'b1; INADDRESS = 3'd3; IN = 8'h5A;
        tick();
        WRITE = 1'b0; OUT1ADDRESS = 3'd3;
        #1;
        n_tests++;
        if (OUT1 !== 8'h5A) begin
            n_fail++;
            $display("FAIL reset_prewrite: got %h want 5a", OUT1);
        end
        #1;
        RESET_N = 1'b0; clear_model();
        #1;
        n_tests++;
        if (OUT1 !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_async: got %h want 00", OUT1);
        end
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(a);
            #1;
            n_tests++;
            if (OUT1 !== 8'h00 || OUT2 !== 8'h00) begin
                n_fail++;
                $display("FAIL reset_all a=%0d: got %h/%h want 00/00", a, OUT1, OUT2);
            end
        end
        @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic test_write_dual_read();
        @(negedge CLK);
        WRITE = 1'b1; BUSYWAIT = 1'b0; INADDRESS = 3'd2; IN = 8'h19;
        tick();
        INADDRESS = 3'd5; IN = 8'h29;
        tick();
        WRITE = 1'b0; OUT1ADDRESS = 3'd2; OUT2ADDRESS = 3'd5;
        #1;
        n_tests++;
        if (OUT1 !== 8'h19 || OUT2 !== 8'h29) begin
            n_fail++;
            $display("FAIL dual_read: got %h/%h want 19/29", OUT1, OUT2);
        end
        OUT1ADDRESS = 3'd5;
        #1;
        n_tests++;
        if (OUT1 !== 8'h29 || OUT2 !== 8'h29) begin
            n_fail++;
            $display("FAIL same_addr_read: got %h/%h want 29/29", OUT1, OUT2);
        end
    endtask

    task automatic test_stall();
        @(negedge CLK);
        WRITE = 1'b1; BUSYWAIT = 1'b1; INADDRESS = 3'd4; IN = 8'hDE;
        OUT1ADDRESS = 3'd4;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_tests++;
            if (OUT1 !== 8'h00) begin
                n_fail++;
                $display("FAIL stall_hold edge=%0d: got %h want 00", k, OUT1);
            end
        end
        @(negedge CLK);
        BUSYWAIT = 1'b0;
        tick();
        WRITE = 1'b0;
        #1;
        n_tests++;
        if (OUT1 !== 8'hDE) begin
            n_fail++;
            $display("FAIL stall_release: got %h want de", OUT1);
        end
    endtask

    task automatic test_write_low();
        @(negedge CLK);
        WRITE = 1'b0; BUSYWAIT = 1'b0; INADDRESS = 3'd0; IN = 8'hFF;
        tick();
        tick();
        for (int a = 0; a < 8; a++) begin
            OUT1ADDRESS = 3'(a); OUT2ADDRESS = 3'(a);
            #1;
            n_tests++;
            if (OUT1 !== model[a] || OUT2 !== model[a]) begin
                n_fail++;
                $display("FAIL write_low a=%0d: got %h/%h want %h", a, OUT1, OUT2, model[a]);
            end
        end
        n_tests++;
        if (model[0] !== 8'h00 || OUT1 !== OUT2) begin
            n_fail++;
            $display("FAIL write_low_reg0: model %h port2 %h want 00", model[0], OUT2);
        end
    endtask

    task automatic test_read_during_write();
        logic [7:0] want_pre;
        @(negedge CLK);
        WRITE = 1'b1; BUSYWAIT = 1'b0; INADDRESS = 3'd6; IN = 8'h10;
        tick();
        @(negedge CLK);
        IN = 8'h77; OUT1ADDRESS = 3'd6;
`ifdef REGFILE_BYPASS_EN
        want_pre = 8'h77;
`else
        want_pre = 8'h10;
`endif
        #1;
        n_tests++;
        if (OUT1 !== want_pre) begin
            n_fail++;
            $display("FAIL rdw_before: got %h want %h", OUT1, want_pre);
        end
        tick();
        WRITE = 1'b0;
        #1;
        n_tests++;
        if (OUT1 !== 8'h77) begin
            n_fail++;
            $display("FAIL rdw_after: got %h want 77", OUT1);
        end
    endtask

    task automatic test_reset_race();
        @(negedge CLK);
        WRITE = 1'b1; BUSYWAIT = 1'b0; INADDRESS = 3'd1; IN = 8'hAB;
        OUT1ADDRESS = 3'd1; OUT2ADDRESS = 3'd1;
        RESET_N = 1'b0; clear_model();
        tick();
        n_tests++;
        if (OUT1 !== 8'h00 || OUT2 !== 8'h00) begin
            n_fail++;
            $display("FAIL race_reset_wins: got %h/%h want 00/00", OUT1, OUT2);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        tick();
        WRITE = 1'b0;
        #1;
        n_tests++;
        if (OUT1 !== 8'hAB) begin
            n_fail++;
            $display("FAIL race_after_release: got %h want ab", OUT1);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            @(negedge CLK);
            if ($urandom_range(0, 39) == 0) begin
                RESET_N = 1'b0; clear_model();
                #1;
                n_tests++;
                if (OUT1 !== 8'h00 || OUT2 !== 8'h00) begin
                    n_fail++;
                    $display("FAIL rand_reset c=%0d: got %h/%h want 00/00", c, OUT1, OUT2);
                end
                RESET_N = 1'b1;
            end
            WRITE       = ($urandom_range(0, 3) != 0);
            BUSYWAIT    = ($urandom_range(0, 3) == 0);
            INADDRESS   = 3'($urandom_range(0, 7));
            IN          = 8'($urandom_range(0, 255));
            OUT1ADDRESS = 3'($urandom_range(0, 7));
            OUT2ADDRESS = ($urandom_range(0, 3) == 0) ? INADDRESS : 3'($urandom_range(0, 7));
            #1;
            n_tests++;
            if (OUT1 !== exp_rd(OUT1ADDRESS) || OUT2 !== exp_rd(OUT2ADDRESS)) begin
                n_fail++;
                $display("FAIL rand_pre c=%0d: got %h/%h want %h/%h", c, OUT1, OUT2,
                         exp_rd(OUT1ADDRESS), exp_rd(OUT2ADDRESS));
            end
            tick();
            n_tests++;
            if (OUT1 !== exp_rd(OUT1ADDRESS) || OUT2 !== exp_rd(OUT2ADDRESS)) begin
                n_fail++;
                $display("FAIL rand_post c=%0d: got %h/%h want %h/%h", c, OUT1, OUT2,
                         exp_rd(OUT1ADDRESS), exp_rd(OUT2ADDRESS));
            end
        end
        WRITE = 1'b0; BUSYWAIT = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; IN = 8'h00; INADDRESS = 3'd0; WRITE = 1'b0;
        BUSYWAIT = 1'b0; OUT1ADDRESS = 3'd0; OUT2ADDRESS = 3'd0;
        clear_model();
        test_reset();
        test_write_dual_read();
        test_stall();
        test_write_low();
        test_read_during_write();
        test_reset_race();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule : tb_reg_file_8x8
